multicycle_sequencer: RTL



---
 rtl/multicycle_sequencer_if.sv | 34 +++
 rtl/multicycle_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multicycle sequencer and the RV64I datapath.
// The master side is the sequencer; the slave side is the datapath.
interface multicycle_sequencer_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       lt;
  logic       ltu;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] imm_src;
  logic [1:0] result_src;
  logic       reg_write;
  logic       trap;

  modport master (
    input  opcode, funct3, zero, lt, ltu, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, alu_src_a, alu_src_b,
           alu_op, imm_src, result_src, reg_write, trap
  );

  modport slave (
    output opcode, funct3, zero, lt, ltu, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, alu_src_a, alu_src_b,
           alu_op, imm_src, result_src, reg_write, trap
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Main control FSM of the multicycle RV64I core: sequences one ALU and one
// unified memory port through fetch/decode/execute/memory/writeback steps.
module multicycle_sequencer #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_sequencer_if.master bus
);
  localparam logic [3:0] S_BOOT   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,
                         S_MEMADR = 4'd3,  S_MEMRD  = 4'd4,  S_MEMWR  = 4'd5,
                         S_MEMWB  = 4'd6,  S_EXEC_R = 4'd7,  S_EXEC_I = 4'd8,
                         S_ALUWB  = 4'd9,  S_BRANCH = 4'd10, S_JAL    = 4'd11,
                         S_JALR   = 4'd12, S_LINK   = 4'd13, S_UPPER  = 4'd14,
                         S_TRAP   = 4'd15;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_R    = 7'b0110011, OP_R32   = 7'b0111011,
                         OP_I    = 7'b0010011, OP_I32   = 7'b0011011,
                         OP_BR   = 7'b1100011, OP_JAL   = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI   = 7'b0110111,
                         OP_AUIPC = 7'b0010111;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic       reg_write;
    logic       trap;
  } ctrl_t;

  logic [3:0] state_q, state_d;
  logic [7:0] wait_q, wait_d;
  ctrl_t      ctl;
  logic       taken;
  logic       stalled;

  always_comb begin
    taken = 1'b0;
    case (bus.funct3)
      3'b000:  taken = bus.zero;
      3'b001:  taken = !bus.zero;
      3'b100:  taken = bus.lt;
      3'b101:  taken = !bus.lt;
      3'b110:  taken = bus.ltu;
      3'b111:  taken = !bus.ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    stalled = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_req    = 1'b1;
        ctl.alu_src_b  = 2'b10;
        ctl.result_src = 2'b10;
        if (bus.mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = S_DECODE;
        end else begin
          stalled = 1'b1;
        end
      end
      S_DECODE: begin
        // ALU forms the branch/JAL target from old_pc + imm while we decode
        ctl.alu_src_a = 2'b01;
        ctl.alu_src_b = 2'b01;
        ctl.imm_src   = (bus.opcode == OP_JAL) ? 3'b011 : 3'b010;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R, OP_R32:      state_d = S_EXEC_R;
          OP_I, OP_I32:      state_d = S_EXEC_I;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctl.alu_src_a = 2'b10;
        ctl.alu_src_b = 2'b01;
        ctl.imm_src   = (bus.opcode == OP_STORE) ? 3'b001 : 3'b000;
        state_d       = (bus.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctl.mem_req = 1'b1;
        ctl.adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
        else               stalled = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_req = 1'b1;
        ctl.mem_we  = 1'b1;
        ctl.adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
        else               stalled = 1'b1;
      end
      S_MEMWB: begin
        ctl.result_src = 2'b01;
        ctl.reg_write  = 1'b1;
        state_d        = S_FETCH;
      end
      S_EXEC_R: begin
        ctl.alu_src_a = 2'b10;
        ctl.alu_op    = 2'b10;
        state_d       = S_ALUWB;
      end
      S_EXEC_I: begin
        ctl.alu_src_a = 2'b10;
        ctl.alu_src_b = 2'b01;
        ctl.alu_op    = 2'b10;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        ctl.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a = 2'b10;
        ctl.alu_op    = 2'b01;
        ctl.pc_write  = taken;
        state_d       = (bus.funct3[2:1] == 2'b01) ? S_TRAP : S_FETCH;
      end
      S_JAL: begin
        ctl.pc_write  = 1'b1;
        ctl.alu_src_a = 2'b01;
        ctl.alu_src_b = 2'b10;
        state_d       = S_ALUWB;
      end
      S_JALR: begin
        ctl.alu_src_a  = 2'b10;
        ctl.alu_src_b  = 2'b01;
        ctl.result_src = 2'b10;
        ctl.pc_write   = 1'b1;
        state_d        = S_LINK;
      end
      S_LINK: begin
        ctl.alu_src_a = 2'b01;
        ctl.alu_src_b = 2'b10;
        state_d       = S_ALUWB;
      end
      S_UPPER: begin
        ctl.alu_src_a = (bus.opcode == OP_LUI) ? 2'b11 : 2'b01;
        ctl.alu_src_b = 2'b01;
        ctl.imm_src   = 3'b100;
        state_d       = S_ALUWB;
      end
      S_TRAP: ctl.trap = 1'b1;
      default: state_d = S_FETCH;
    endcase
    // a stall already MAX_WAIT cycles long traps unless ready shows up now
    if (stalled && wait_q == WAIT_LIM) state_d = S_TRAP;
    wait_d = (state_d != state_q) ? 8'd0 : wait_q + {7'd0, stalled};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.mem_req    = ctl.mem_req;
  assign bus.mem_we     = ctl.mem_we;
  assign bus.adr_src    = ctl.adr_src;
  assign bus.ir_write   = ctl.ir_write;
  assign bus.pc_write   = ctl.pc_write;
  assign bus.alu_src_a  = ctl.alu_src_a;
  assign bus.alu_src_b  = ctl.alu_src_b;
  assign bus.alu_op     = ctl.alu_op;
  assign bus.imm_src    = ctl.imm_src;
  assign bus.result_src = ctl.result_src;
  assign bus.reg_write  = ctl.reg_write;
  assign bus.trap       = ctl.trap;
endmodule
